// File: rtl/histeq_sched_pkg.sv
// Shared types for the histogram-equalisation frame scheduler.
package histeq_sched_pkg;

    localparam int DW_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        PEND,
        STAT_ARM,
        STAT_RUN,
        WAIT_LUT,
        EQ_ARM,
        EQ_RUN
    } sched_state_t;

endpackage

// File: rtl/vsync_edge_det.sv
// Registers in_vsync once and reports its rising and falling edges combinationally.
module vsync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic in_vsync,
    output logic rise,
    output logic fall
);

    logic vsync_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vsync_r <= 1'b0;
        else        vsync_r <= in_vsync;
    end

    assign rise = in_vsync & ~vsync_r;
    assign fall = ~in_vsync & vsync_r;

endmodule

// File: rtl/histeq_frame_sched.sv
// Two-pass frame scheduler: one whole frame to hist_stat, then one whole frame to histEQ_proc.
// Optional WAIT_LUT watchdog enabled by defining HISTEQ_SCHED_TIMEOUT_EN.
module histeq_frame_sched
    import histeq_sched_pkg::*;
#(
    parameter int          DW          = DW_DEF,
    parameter int          CNT_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cont_en,
    input  logic             in_vsync,
    input  logic             in_href,
    input  logic [DW-1:0]    in_gray,
    input  logic             histEQ_start_flag,
    output logic             stat_vsync,
    output logic             stat_href,
    output logic [DW-1:0]    stat_gray,
    output logic             eq_vsync,
    output logic             eq_href,
    output logic [DW-1:0]    eq_gray,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             timeout_err
);

    sched_state_t state, state_nxt;
    logic         rise, fall;
    logic         drop_inc, done_nxt, timeout_hit;
    logic         stat_open, eq_open;

    vsync_edge_det u_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vsync (in_vsync),
        .rise     (rise),
        .fall     (fall)
    );

`ifdef HISTEQ_SCHED_TIMEOUT_EN
    localparam int unsigned          TW        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0]        WAIT_LAST = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0]                   wait_cnt;

    // Counter holds at the limit so a flag seen mid-frame cannot let it wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    wait_cnt <= '0;
        else if (state != WAIT_LUT)    wait_cnt <= '0;
        else if (wait_cnt != WAIT_LAST) wait_cnt <= wait_cnt + 1'b1;
    end

    assign timeout_hit = (state == WAIT_LUT) && !histEQ_start_flag && (wait_cnt == WAIT_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        drop_inc  = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                drop_inc = rise;
                if (start) state_nxt = in_vsync ? PEND : STAT_ARM;
            end
            PEND: begin
                drop_inc = rise;
                if (!in_vsync) state_nxt = STAT_ARM;
            end
            STAT_ARM: if (rise) state_nxt = STAT_RUN;
            STAT_RUN: if (fall) state_nxt = WAIT_LUT;
            WAIT_LUT: begin
                drop_inc = rise;
                if (histEQ_start_flag && !in_vsync) state_nxt = EQ_ARM;
                else if (timeout_hit)               state_nxt = IDLE;
            end
            EQ_ARM: if (rise) state_nxt = EQ_RUN;
            EQ_RUN: begin
                if (fall) begin
                    done_nxt  = 1'b1;
                    state_nxt = cont_en ? STAT_ARM : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            frame_done  <= done_nxt;
            timeout_err <= timeout_hit;
            if (drop_inc && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign busy      = (state != IDLE);
    assign stat_open = (state == STAT_ARM) || (state == STAT_RUN);
    assign eq_open   = (state == EQ_ARM) || (state == EQ_RUN);

    assign stat_vsync = stat_open & in_vsync;
    assign stat_href  = stat_open & in_href;
    assign stat_gray  = stat_open ? in_gray : '0;
    assign eq_vsync   = eq_open & in_vsync;
    assign eq_href    = eq_open & in_href;
    assign eq_gray    = eq_open ? in_gray : '0;

endmodule

// File: tb/tb_histeq_frame_sched.sv
// Scoreboard bench for histeq_frame_sched: expected pixels queued per channel, popped at negedge.
module tb_histeq_frame_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        cont_en = 1'b0;
    logic        in_vsync = 1'b0;
    logic        in_href = 1'b0;
    logic [7:0]  in_gray = '0;
    logic        flag = 1'b0;
    logic        stat_vsync, stat_href, eq_vsync, eq_href;
    logic [7:0]  stat_gray, eq_gray;
    logic        busy, frame_done, timeout_err;
    logic [15:0] drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] stat_q[$];
    logic [7:0] eq_q[$];
    int stat_frames = 0, eq_frames = 0, done_cycles = 0, busy_low = 0;
    bit watch_busy = 1'b0;
    bit prev_sv = 1'b0, prev_ev = 1'b0;

    always #5 clk = ~clk;

    histeq_frame_sched #(.DW(8), .CNT_W(16), .TIMEOUT_CYC(100)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .cont_en           (cont_en),
        .in_vsync          (in_vsync),
        .in_href           (in_href),
        .in_gray           (in_gray),
        .histEQ_start_flag (flag),
        .stat_vsync        (stat_vsync),
        .stat_href         (stat_href),
        .stat_gray         (stat_gray),
        .eq_vsync          (eq_vsync),
        .eq_href           (eq_href),
        .eq_gray           (eq_gray),
        .busy              (busy),
        .frame_done        (frame_done),
        .drop_cnt          (drop_cnt),
        .timeout_err       (timeout_err)
    );

    task automatic monitor();
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            if (stat_href) begin
                n_tests++;
                if (stat_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stat_unexpected: got pixel %02h, required none", stat_gray);
                end else begin
                    exp = stat_q.pop_front();
                    if (stat_gray !== exp) begin
                        n_fail++;
                        $display("FAIL stat_pixel: got %02h, required %02h", stat_gray, exp);
                    end
                end
            end else if (stat_gray !== 8'h00) begin
                n_tests++;
                n_fail++;
                $display("FAIL stat_gray_idle: got %02h, required 00", stat_gray);
            end
            if (eq_href) begin
                n_tests++;
                if (eq_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL eq_unexpected: got pixel %02h, required none", eq_gray);
                end else begin
                    exp = eq_q.pop_front();
                    if (eq_gray !== exp) begin
                        n_fail++;
                        $display("FAIL eq_pixel: got %02h, required %02h", eq_gray, exp);
                    end
                end
            end else if (eq_gray !== 8'h00) begin
                n_tests++;
                n_fail++;
                $display("FAIL eq_gray_idle: got %02h, required 00", eq_gray);
            end
            if (stat_vsync && !prev_sv) stat_frames++;
            if (eq_vsync && !prev_ev) eq_frames++;
            prev_sv = stat_vsync;
            prev_ev = eq_vsync;
            if (frame_done) done_cycles++;
            if (watch_busy && !busy) busy_low++;
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; start = 1'b0; cont_en = 1'b0; flag = 1'b0;
        in_vsync = 1'b0; in_href = 1'b0; in_gray = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // 4x4 frame; start/flag may be asserted at a given frame cycle (0 = never)
    task automatic send_frame(input logic [7:0] base, input bit to_stat, input bit to_eq,
                              input int start_at, input int flag_at, input int gap);
        int cyc = 0;
        logic [7:0] v;
        @(posedge clk); #1 cyc++; start = (cyc == start_at); if (cyc == flag_at) flag = 1'b1;
        in_vsync = 1'b1;
        @(posedge clk); #1 cyc++; start = (cyc == start_at); if (cyc == flag_at) flag = 1'b1;
        for (int l = 0; l < 4; l++) begin
            for (int p = 0; p < 4; p++) begin
                @(posedge clk); #1 cyc++; start = (cyc == start_at); if (cyc == flag_at) flag = 1'b1;
                v = base + 8'(l * 4 + p);
                in_href = 1'b1;
                in_gray = v;
                if (to_stat) stat_q.push_back(v);
                if (to_eq) eq_q.push_back(v);
            end
            @(posedge clk); #1 cyc++; start = (cyc == start_at); if (cyc == flag_at) flag = 1'b1;
            in_href = 1'b0;
            in_gray = '0;
        end
        @(posedge clk); #1 start = 1'b0;
        in_vsync = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_drained(input string tag);
        n_tests++;
        if (stat_q.size() != 0 || eq_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drained: got %0d stat / %0d eq pixels outstanding, required 0 / 0",
                     tag, stat_q.size(), eq_q.size());
            stat_q.delete();
            eq_q.delete();
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; in_vsync = 1'b1; in_href = 1'b1; in_gray = 8'hA5;
        #2;
        n_tests++;
        if ({stat_vsync, stat_href, stat_gray, eq_vsync, eq_href, eq_gray, busy, frame_done, timeout_err} !== '0
            || drop_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got sv=%b sh=%b sg=%02h ev=%b eh=%b eg=%02h busy=%b done=%b to=%b drop=%0d, required all 0",
                     stat_vsync, stat_href, stat_gray, eq_vsync, eq_href, eq_gray, busy, frame_done, timeout_err, drop_cnt);
        end
        apply_reset();
    endtask

    task automatic test_single_sequence();
        int sf0, ef0, d0;
        apply_reset();
        sf0 = stat_frames; ef0 = eq_frames; d0 = done_cycles;
        pulse_start();
        send_frame(8'h10, 1, 0, 0, 0, 3);
        repeat (20) begin @(posedge clk); #1; end
        flag = 1'b1;
        send_frame(8'h40, 0, 1, 0, 0, 3);
        flag = 1'b0;
        check_drained("single");
        n_tests++;
        if (stat_frames - sf0 !== 1 || eq_frames - ef0 !== 1) begin
            n_fail++;
            $display("FAIL single_frames: got stat=%0d eq=%0d, required 1/1", stat_frames - sf0, eq_frames - ef0);
        end
        n_tests++;
        if (done_cycles - d0 !== 1) begin
            n_fail++;
            $display("FAIL single_done: got %0d cycles, required 1", done_cycles - d0);
        end
        n_tests++;
        if (drop_cnt !== 16'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_end: got drop=%0d busy=%b, required 0/0", drop_cnt, busy);
        end
    endtask

    task automatic test_start_mid_frame();
        int sf0;
        logic [15:0] drop0;
        apply_reset();
        sf0 = stat_frames;
        send_frame(8'h20, 0, 0, 5, 0, 3);
        drop0 = drop_cnt;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_start_busy: got %b, required 1", busy);
        end
        send_frame(8'h60, 1, 0, 0, 0, 3);
        check_drained("mid_start");
        n_tests++;
        if (stat_frames - sf0 !== 1 || drop_cnt !== drop0) begin
            n_fail++;
            $display("FAIL mid_start: got stat frames=%0d drop delta=%0d, required 1/0",
                     stat_frames - sf0, drop_cnt - drop0);
        end
    endtask

    task automatic test_no_flag();
        int ef0;
        apply_reset();
        ef0 = eq_frames;
        pulse_start();
        send_frame(8'h30, 1, 0, 0, 0, 3);
        for (int f = 0; f < 3; f++) send_frame(8'h80 + 8'(f * 16), 0, 0, 0, 0, 3);
        check_drained("no_flag");
        n_tests++;
        if (drop_cnt !== 16'd3 || eq_frames != ef0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL no_flag: got drop=%0d eq frames=%0d busy=%b, required 3/0/1",
                     drop_cnt, eq_frames - ef0, busy);
        end
    endtask

    task automatic test_flag_mid_frame();
        int ef0, d0;
        apply_reset();
        ef0 = eq_frames; d0 = done_cycles;
        pulse_start();
        send_frame(8'h05, 1, 0, 0, 0, 3);
        send_frame(8'h50, 0, 0, 0, 6, 3);
        send_frame(8'h90, 0, 1, 0, 0, 3);
        flag = 1'b0;
        check_drained("flag_mid");
        n_tests++;
        if (drop_cnt !== 16'd1 || eq_frames - ef0 !== 1 || done_cycles - d0 !== 1) begin
            n_fail++;
            $display("FAIL flag_mid: got drop=%0d eq frames=%0d done=%0d, required 1/1/1",
                     drop_cnt, eq_frames - ef0, done_cycles - d0);
        end
    endtask

    task automatic test_back_to_back();
        int sf0, ef0, d0;
        apply_reset();
        sf0 = stat_frames; ef0 = eq_frames; d0 = done_cycles;
        cont_en = 1'b1;
        flag = 1'b1;
        pulse_start();
        watch_busy = 1'b1;
        send_frame(8'h00, 1, 0, 0, 0, 3);
        send_frame(8'h40, 0, 1, 0, 0, 3);
        send_frame(8'h80, 1, 0, 0, 0, 3);
        send_frame(8'hC0, 0, 1, 0, 0, 3);
        watch_busy = 1'b0;
        check_drained("b2b");
        n_tests++;
        if (stat_frames - sf0 !== 2 || eq_frames - ef0 !== 2 || done_cycles - d0 !== 2) begin
            n_fail++;
            $display("FAIL b2b_counts: got stat=%0d eq=%0d done=%0d, required 2/2/2",
                     stat_frames - sf0, eq_frames - ef0, done_cycles - d0);
        end
        n_tests++;
        if (busy_low !== 0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_busy: got %0d idle cycles, busy=%b, required 0 and 1", busy_low, busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        apply_reset();
        pulse_start();
        @(posedge clk); #1 in_vsync = 1'b1;
        @(posedge clk); #1 in_href = 1'b1; in_gray = 8'h11; stat_q.push_back(8'h11);
        @(posedge clk); #1 in_gray = 8'h12; stat_q.push_back(8'h12);
        @(posedge clk); #1 in_gray = 8'h13;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({stat_vsync, stat_href, stat_gray, busy, drop_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got sv=%b sh=%b sg=%02h busy=%b drop=%0d, required all 0",
                     stat_vsync, stat_href, stat_gray, busy, drop_cnt);
        end
        @(posedge clk); #1 in_vsync = 1'b0; in_href = 1'b0; in_gray = '0;
        @(posedge clk); #1 rst_n = 1'b1;
        check_drained("reset_mid");
    endtask

    task automatic test_timeout();
        int hit_at = -1;
        apply_reset();
        pulse_start();
        send_frame(8'h70, 1, 0, 0, 0, 0);
        @(posedge clk); #1;
        for (int k = 1; k <= 150 && hit_at < 0; k++) begin
            @(posedge clk); #1;
            if (timeout_err) hit_at = k;
        end
        check_drained("timeout");
`ifdef HISTEQ_SCHED_TIMEOUT_EN
        n_tests++;
        if (hit_at !== 100) begin
            n_fail++;
            $display("FAIL timeout_at: got pulse at cycle %0d, required 100", hit_at);
        end
        @(posedge clk); #1;
        n_tests++;
        if (timeout_err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_after: got err=%b busy=%b, required 0/0", timeout_err, busy);
        end
`else
        n_tests++;
        if (hit_at !== -1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL no_timeout: got pulse at %0d busy=%b, required none and 1", hit_at, busy);
        end
`endif
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_single_sequence();
        test_start_mid_frame();
        test_no_flag();
        test_flag_mid_frame();
        test_back_to_back();
        test_reset_mid_frame();
        test_timeout();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
